shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
Multi-cycle controller that sequences the shared 32-bit combinational shifter to execute the full MIPS shift/rotate op set. The shifter only supports logical left and right shifts.
- SLL and SRL use one pass.
- SRA, ROTL and ROTR are built from two passes plus OR/mask logic.
- Sits between the ALU/execute issue logic (valid/ready in) and the writeback stage (valid/ready out).
- Owns the shifter's toshift/number/direction inputs exclusively.

Parameters:
WIDTH, 32, data width; fixed to the shifter width, not user-overridable in practice
SHW, 5, shift-amount width, log2(WIDTH)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  request valid
in_ready  out  1  sequencer can accept a request
in_op  in  3  000 SLL, 001 SRL, 010 SRA, 011 ROTL, 100 ROTR, 101-111 reserved
in_data  in  WIDTH  operand
in_amt  in  SHW  shift amount
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_data  out  WIDTH  result
sh_toshift  out  WIDTH  to shifter toshift
sh_number  out  SHW  to shifter number
sh_direction  out  1  to shifter direction (0 left, 1 right)
sh_shifted  in  WIDTH  from shifter shifted (combinational)

Behaviour:
- States: IDLE, PASS1, PASS2, DONE. Encoding is free.
- Reset (reset=0, asynchronous):
  - state=IDLE; out_valid=0; out_data=0.
  - Internal op/operand/amount/partial registers are cleared to 0.
  - sh_* outputs=0.
- Reset asserted mid-operation aborts the operation. No result is produced and no handshake completes.
- in_ready = (state==IDLE); it is combinational from state only.
- IDLE:
  - A request is accepted on an edge where in_valid & in_ready.
  - op, data and amt are latched; state -> PASS1.
- PASS1 drives the shifter from the latched values:
  - SLL and ROTL: toshift=data, number=amt, direction=0.
  - SRL, SRA and ROTR: toshift=data, number=amt, direction=1.
  - Reserved ops: number=0. This is a pass-through.
- PASS1 edge: partial <= sh_shifted.
  - If the op is SLL, SRL or reserved, or the op is ROTL/ROTR with amt==0: out_data <= sh_shifted, out_valid <= 1, state -> DONE.
  - Otherwise state -> PASS2.
- PASS2 drives the shifter as follows:
  - ROTL: toshift=data, number=(0-amt) mod 32, direction=1.
  - ROTR: toshift=data, number=(0-amt) mod 32, direction=0.
  - SRA: toshift=all-ones, number=amt, direction=1.
- PASS2 edge: out_valid <= 1, state -> DONE, and:
  - ROTL/ROTR: out_data <= partial | sh_shifted.
  - SRA: out_data <= data[31] ? (partial | ~sh_shifted) : partial.
- SRA always takes two passes, including amt==0. With amt==0 the mask ~all-ones is 0, so the result equals data.
- DONE:
  - out_data and out_valid are held stable while out_ready=0.
  - On an edge with out_ready=1: out_valid <= 0, state -> IDLE.
  - A new request cannot be accepted in the same edge; in_ready rises the cycle after.
- sh_* outputs are don't-care-stable in IDLE/DONE and hold their last values. They must not glitch combinationally from in_* inputs.
- Latency from accept edge to out_valid high:
  - 1 cycle for single-pass ops.
  - 2 cycles for SRA and for ROTL/ROTR with amt!=0.
- Throughput: at most one op per 3 cycles (single-pass) or per 4 cycles (two-pass) with out_ready tied high.
- in_* changes while not in IDLE are ignored.

Test Plan:
1. Single-pass shifts, out_ready=1:
   - SLL in_data=0x00000001, amt=31 -> out_data=0x80000000, out_valid one cycle after accept.
   - SRL in_data=0x80000000, amt=31 -> out_data=0x00000001.
2. SRA:
   - in_data=0x80000000, amt=31 -> out_data=0xFFFFFFFF, two cycles after accept.
   - in_data=0x70000000, amt=4 -> out_data=0x07000000.
   - in_data=0x80000000, amt=0 -> out_data=0x80000000.
3. Rotates:
   - ROTR in_data=0x00000001, amt=1 -> out_data=0x80000000.
   - ROTL in_data=0x80000001, amt=4 -> out_data=0x00000018.
   - ROTL in_data=0x12345678, amt=0 -> out_data=0x12345678 with 1-cycle latency.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid.
   - out_data stays stable and in_ready stays 0, even with in_valid=1 driven with a new op.
   - On release: one handshake, in_ready=1 next cycle, and the second op completes correctly.
5. Reset:
   - Assert reset during PASS2 of a ROTR -> immediately out_valid=0, out_data=0, in_ready=1.
   - After release, no stale result appears, and a fresh SLL 0x1 by 4 -> 0x10.
6. Reserved op 110 with in_data=0xDEADBEEF, amt=7 -> out_data=0xDEADBEEF, single-pass latency.

Source files
------------

// File: rtl/shift_sequencer.sv
// Multi-cycle sequencer that drives a shared logical-only 32-bit shifter to implement
// SLL, SRL, SRA, ROTL and ROTR. Two-pass ops combine the pass results with OR/mask logic.
module shift_sequencer #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [WIDTH-1:0] sh_toshift,
    output logic [SHW-1:0]   sh_number,
    output logic             sh_direction,
    input  logic [WIDTH-1:0] sh_shifted
);

    localparam logic [2:0] OP_SLL  = 3'b000;
    localparam logic [2:0] OP_SRL  = 3'b001;
    localparam logic [2:0] OP_SRA  = 3'b010;
    localparam logic [2:0] OP_ROTL = 3'b011;
    localparam logic [2:0] OP_ROTR = 3'b100;

    typedef enum logic [1:0] {
        IDLE,
        PASS1,
        PASS2,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [2:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic [SHW-1:0]   amt_q;
    logic [WIDTH-1:0] partial_q;

    logic             accept;
    logic             is_rot;
    logic             single_pass;
    logic             pass1_dir;
    logic [SHW-1:0]   pass1_num;
    logic [WIDTH-1:0] pass2_toshift;
    logic [SHW-1:0]   pass2_num;
    logic             pass2_dir;
    logic [WIDTH-1:0] sra_result;
    logic [WIDTH-1:0] pass2_result;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;

    assign is_rot      = (op_q == OP_ROTL) || (op_q == OP_ROTR);
    assign single_pass = (op_q == OP_SLL) || (op_q == OP_SRL) || (op_q > OP_ROTR) ||
                         (is_rot && (amt_q == '0));

    // Reserved opcodes shift by zero so the operand passes straight through.
    assign pass1_dir = (in_op == OP_SRL) || (in_op == OP_SRA) || (in_op == OP_ROTR);
    assign pass1_num = (in_op > OP_ROTR) ? '0 : in_amt;

    // Second pass: rotates fetch the wrapped-around bits; SRA builds the sign-fill mask.
    assign pass2_toshift = (op_q == OP_SRA) ? '1 : data_q;
    assign pass2_num     = (op_q == OP_SRA) ? amt_q : (SHW'(0) - amt_q);
    assign pass2_dir     = (op_q != OP_ROTR);

    assign sra_result   = data_q[WIDTH-1] ? (partial_q | ~sh_shifted) : partial_q;
    assign pass2_result = (op_q == OP_SRA) ? sra_result : (partial_q | sh_shifted);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = PASS1;
            PASS1:   state_next = single_pass ? DONE : PASS2;
            PASS2:   state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Shifter inputs are registered so they never follow in_* combinationally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q         <= '0;
            data_q       <= '0;
            amt_q        <= '0;
            partial_q    <= '0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            sh_toshift   <= '0;
            sh_number    <= '0;
            sh_direction <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q         <= in_op;
                        data_q       <= in_data;
                        amt_q        <= in_amt;
                        sh_toshift   <= in_data;
                        sh_number    <= pass1_num;
                        sh_direction <= pass1_dir;
                    end
                end
                PASS1: begin
                    partial_q <= sh_shifted;
                    if (single_pass) begin
                        out_data  <= sh_shifted;
                        out_valid <= 1'b1;
                    end else begin
                        sh_toshift   <= pass2_toshift;
                        sh_number    <= pass2_num;
                        sh_direction <= pass2_dir;
                    end
                end
                PASS2: begin
                    out_data  <= pass2_result;
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: models the external logical shifter and
// scores results through a queue filled at request time and drained at handshake.
module tb_shift_sequencer;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       in_op = '0;
    logic [WIDTH-1:0] in_data = '0;
    logic [SHW-1:0]   in_amt = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_data;
    logic [WIDTH-1:0] sh_toshift;
    logic [SHW-1:0]   sh_number;
    logic             sh_direction;
    logic [WIDTH-1:0] sh_shifted;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] data;
        logic [4:0]  amt;
        logic [31:0] expected;
        int          latency;
    } vec_t;

    vec_t        vecs[10];
    logic [31:0] sb[$];
    int          checks = 0;
    int          errors = 0;

    shift_sequencer #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_data(in_data), .in_amt(in_amt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .sh_toshift(sh_toshift), .sh_number(sh_number),
        .sh_direction(sh_direction), .sh_shifted(sh_shifted)
    );

    always #5 clk = ~clk;

    // The shared shifter: logical shifts only, purely combinational.
    assign sh_shifted = sh_direction ? (sh_toshift >> sh_number) : (sh_toshift << sh_number);

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic report_fail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: bound expired, got no event, expected one", name);
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] d, input logic [4:0] a);
        int unsigned back;
        back = 32 - int'(a);
        case (op)
            3'b000:  return d << a;
            3'b001:  return d >> a;
            3'b010:  return $signed(d) >>> a;
            3'b011:  return (a == 0) ? d : ((d << a) | (d >> back));
            3'b100:  return (a == 0) ? d : ((d >> a) | (d << back));
            default: return d;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [4:0] a);
        if (op == 3'b010) return 2;
        if ((op == 3'b011 || op == 3'b100) && a != 0) return 2;
        return 1;
    endfunction

    // Results are scored on the falling edge preceding the handshake edge.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_result: got 0x%08h, expected no result", out_data);
            end else begin
                check_output("result", out_data, sb.pop_front());
            end
        end
    end

    task automatic wait_ready(input string name);
        int waited = 0;
        while (!in_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) report_fail(name);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) report_fail("out_valid_timeout");
    endtask

    task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] data, input logic [4:0] amt,
                                  input logic [31:0] expected, input int latency);
        int lat;
        wait_ready("in_ready_timeout");
        in_valid = 1'b1;
        in_op    = op;
        in_data  = data;
        in_amt   = amt;
        sb.push_back(expected);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_op    = 3'($urandom);
        in_data  = $urandom;
        in_amt   = 5'($urandom);
        check_output("in_ready_busy", 32'(in_ready), 32'd0);
        wait_valid(lat);
        check_output("latency", 32'(lat), 32'(latency));
        @(posedge clk); #1;
        check_output("out_valid_after_handshake", 32'(out_valid), 32'd0);
        check_output("in_ready_after_handshake", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        logic [2:0]  rop;
        logic [31:0] rdata;
        logic [4:0]  ramt;

        vecs[0] = '{3'b000, 32'h00000001, 5'd31, 32'h80000000, 1};
        vecs[1] = '{3'b001, 32'h80000000, 5'd31, 32'h00000001, 1};
        vecs[2] = '{3'b010, 32'h80000000, 5'd31, 32'hFFFFFFFF, 2};
        vecs[3] = '{3'b010, 32'h70000000, 5'd4,  32'h07000000, 2};
        vecs[4] = '{3'b010, 32'h80000000, 5'd0,  32'h80000000, 2};
        vecs[5] = '{3'b100, 32'h00000001, 5'd1,  32'h80000000, 2};
        vecs[6] = '{3'b011, 32'h80000001, 5'd4,  32'h00000018, 2};
        vecs[7] = '{3'b011, 32'h12345678, 5'd0,  32'h12345678, 1};
        vecs[8] = '{3'b110, 32'hDEADBEEF, 5'd7,  32'hDEADBEEF, 1};
        vecs[9] = '{3'b010, 32'hF0F00000, 5'd8,  32'hFFF0F000, 2};

        repeat (2) @(posedge clk);
        #1;
        check_output("reset_out_valid", 32'(out_valid), 32'd0);
        check_output("reset_out_data", out_data, 32'd0);
        check_output("reset_in_ready", 32'(in_ready), 32'd1);
        check_output("reset_sh_toshift", sh_toshift, 32'd0);
        check_output("reset_sh_number", 32'(sh_number), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++)
            apply_stimulus(vecs[i].op, vecs[i].data, vecs[i].amt, vecs[i].expected, vecs[i].latency);

        for (int i = 0; i < 12; i++) begin
            rop   = 3'($urandom_range(0, 4));
            rdata = $urandom;
            ramt  = 5'($urandom_range(0, 31));
            apply_stimulus(rop, rdata, ramt, ref_result(rop, rdata, ramt), ref_latency(rop, ramt));
        end

        // Backpressure: result must hold while a second request waits on in_valid.
        out_ready = 1'b0;
        wait_ready("bp_ready_timeout");
        in_valid = 1'b1;
        in_op    = 3'b011;
        in_data  = 32'h80000001;
        in_amt   = 5'd4;
        sb.push_back(32'h00000018);
        @(posedge clk); #1;
        in_op   = 3'b010;
        in_data = 32'h70000000;
        in_amt  = 5'd4;
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_output("bp_out_data_stable", out_data, 32'h00000018);
            check_output("bp_out_valid_held", 32'(out_valid), 32'd1);
            check_output("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        sb.push_back(32'h07000000);
        @(posedge clk); #1;
        check_output("bp_out_valid_released", 32'(out_valid), 32'd0);
        check_output("bp_in_ready_after_release", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_output("bp_second_accepted", 32'(in_ready), 32'd0);
        wait_valid(lat);
        check_output("bp_second_latency", 32'(lat), 32'd2);
        @(posedge clk); #1;

        // Reset during the second pass of a rotate discards the operation.
        wait_ready("rst_ready_timeout");
        in_valid = 1'b1;
        in_op    = 3'b100;
        in_data  = 32'h00000001;
        in_amt   = 5'd1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check_output("rst_out_valid", 32'(out_valid), 32'd0);
        check_output("rst_out_data", out_data, 32'd0);
        check_output("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check_output("rst_no_stale_result", 32'(out_valid), 32'd0);
        end
        apply_stimulus(3'b000, 32'h00000001, 5'd4, 32'h00000010, 1);

        check_output("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
